// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the pipeline hazard scoreboard.
package hazard_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      LD_WAIT = 1'b1
   } hzState_t;

   // Forward-select code meaning "take the operand from the register file".
   localparam int FWD_RF = 0;

   // MIPS $zero is hardwired to zero and must never be forwarded.
   localparam int MIPS_ZERO_REG = 0;

   // Forward-select code for downstream stage k (stage 0 = ID/EX).
   function automatic int FWD_STAGE(input int k);
      return k + 1;
   endfunction

   // Ceiling log2, used to size counters and select codes.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: operand/destination information in, pipeline control out.
interface hazard_scoreboard_if #(
   parameter int AW         = 5,
   parameter int FWD_STAGES = 3,
   parameter int FW         = 2
);
   logic [AW-1:0]            i_rs;
   logic [AW-1:0]            i_rt;
   logic                     i_rs_used;
   logic                     i_rt_used;
   logic [FWD_STAGES*AW-1:0] i_dst;
   logic [FWD_STAGES-1:0]    i_regwrite;
   logic                     i_memread;
   logic                     i_md_start;
   logic                     i_md_read;
   logic                     i_flush;
   logic [FW-1:0]            o_forward_a;
   logic [FW-1:0]            o_forward_b;
   logic                     o_bubble;
   logic                     o_pcwrite;
   logic                     o_idIfwrite;
   logic                     o_idIf_flush;
   logic                     o_md_busy;
   logic [31:0]              o_stall_cnt;

   // Pipeline side: describes the instructions in flight, consumes control.
   modport master (
      output i_rs, i_rt, i_rs_used, i_rt_used, i_dst, i_regwrite,
             i_memread, i_md_start, i_md_read, i_flush,
      input  o_forward_a, o_forward_b, o_bubble, o_pcwrite, o_idIfwrite,
             o_idIf_flush, o_md_busy, o_stall_cnt
   );

   // Hazard unit side.
   modport slave (
      input  i_rs, i_rt, i_rs_used, i_rt_used, i_dst, i_regwrite,
             i_memread, i_md_start, i_md_read, i_flush,
      output o_forward_a, o_forward_b, o_bubble, o_pcwrite, o_idIfwrite,
             o_idIf_flush, o_md_busy, o_stall_cnt
   );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Priority forwarding encoder for one source operand: nearest producing stage wins.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int AW         = 5,
   parameter int FWD_STAGES = 3,
   parameter int FW         = 2
) (
   input  logic [AW-1:0]            i_src,
   input  logic                     i_used,
   input  logic [FWD_STAGES*AW-1:0] i_dst,
   input  logic [FWD_STAGES-1:0]    i_regwrite,
   output logic [FW-1:0]            o_code
);

   // Scan from the oldest stage to the youngest so the lowest matching stage overrides.
   always_comb begin
      o_code = FW'(FWD_RF);
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (i_used && i_regwrite[k] &&
             (i_dst[k*AW +: AW] != AW'(MIPS_ZERO_REG)) &&
             (i_dst[k*AW +: AW] == i_src)) begin
            o_code = FW'(FWD_STAGE(k));
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: operand forwarding, load-use and mult/div stalls, redirect flush, stall counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int AW         = 5,
   parameter int FWD_STAGES = 3,
   parameter int LOAD_LAT   = 1,
   parameter int MD_LAT     = 32,
   parameter int FW         = clog2(FWD_STAGES + 1)
) (
   input logic                i_clk,
   input logic                i_rst,
   hazard_scoreboard_if.slave hz
);

   localparam int LW = clog2(LOAD_LAT + 1);
   localparam int MW = clog2(MD_LAT + 1);

   hzState_t      state_q;
   logic [LW-1:0] ldCnt_q;
   logic [MW-1:0] mdCnt_q;
   logic [MW-1:0] mdCnt_d;
   logic [31:0]   stallCnt_q;
   logic [31:0]   stallCnt_d;

   logic [FW-1:0] fwdA;
   logic [FW-1:0] fwdB;
   logic [AW-1:0] dst0;
   logic          ldHz;
   logic          mdHz;
   logic          stall;

   hazard_fwd_sel #(.AW(AW), .FWD_STAGES(FWD_STAGES), .FW(FW)) uFwdA (
      .i_src      (hz.i_rs),
      .i_used     (hz.i_rs_used),
      .i_dst      (hz.i_dst),
      .i_regwrite (hz.i_regwrite),
      .o_code     (fwdA)
   );

   hazard_fwd_sel #(.AW(AW), .FWD_STAGES(FWD_STAGES), .FW(FW)) uFwdB (
      .i_src      (hz.i_rt),
      .i_used     (hz.i_rt_used),
      .i_dst      (hz.i_dst),
      .i_regwrite (hz.i_regwrite),
      .o_code     (fwdB)
   );

   assign dst0 = hz.i_dst[AW-1:0];

   // Hazard detection and the combined stall request; a redirect always cancels the stall.
   always_comb begin
      ldHz  = hz.i_memread && (dst0 != AW'(MIPS_ZERO_REG)) &&
              ((hz.i_rs_used && (dst0 == hz.i_rs)) ||
               (hz.i_rt_used && (dst0 == hz.i_rt)));
      mdHz  = hz.i_md_read && (mdCnt_q != '0);
      stall = (ldHz || (state_q == LD_WAIT) || mdHz) && !hz.i_flush;
   end

   // Pipeline control outputs; reset forces the pass-through values.
   always_comb begin
      hz.o_forward_a  = '0;
      hz.o_forward_b  = '0;
      hz.o_bubble     = 1'b1;
      hz.o_pcwrite    = 1'b1;
      hz.o_idIfwrite  = 1'b1;
      hz.o_idIf_flush = 1'b0;
      if (!i_rst) begin
         hz.o_forward_a = fwdA;
         hz.o_forward_b = fwdB;
         if (hz.i_flush) begin
            hz.o_idIf_flush = 1'b1;
            hz.o_bubble     = 1'b0;
         end else if (stall) begin
            hz.o_bubble    = 1'b0;
            hz.o_pcwrite   = 1'b0;
            hz.o_idIfwrite = 1'b0;
         end
      end
   end

   assign hz.o_md_busy   = (mdCnt_q != '0);
   assign hz.o_stall_cnt = stallCnt_q;

   // Load-use FSM holds the stall for the extra load-latency cycles beyond the first.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         ldCnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ldHz && !hz.i_flush && (LOAD_LAT > 1)) begin
                  state_q <= LD_WAIT;
                  ldCnt_q <= LW'(LOAD_LAT - 1);
               end
            end
            LD_WAIT: begin
               if (hz.i_flush || (ldCnt_q <= LW'(1))) begin
                  state_q <= IDLE;
                  ldCnt_q <= '0;
               end else begin
                  ldCnt_q <= ldCnt_q - LW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               ldCnt_q <= '0;
            end
         endcase
      end
   end

   // Next-state for the mult/div busy count and the saturating stall counter.
   always_comb begin
      mdCnt_d = mdCnt_q;
      if (hz.i_md_start && !stall) begin
         mdCnt_d = MW'(MD_LAT);
      end else if (mdCnt_q != '0) begin
         mdCnt_d = mdCnt_q - MW'(1);
      end
      stallCnt_d = stallCnt_q;
      if (stall && (stallCnt_q != 32'hFFFF_FFFF)) begin
         stallCnt_d = stallCnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mdCnt_q    <= '0;
         stallCnt_q <= '0;
      end else begin
         mdCnt_q    <= mdCnt_d;
         stallCnt_q <= stallCnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for the hazard scoreboard, built with LOAD_LAT=3 and MD_LAT=4.
module tb_hazard_scoreboard;

   logic i_clk;
   logic i_rst;
   int   vectors;
   int   miscompares;

   hazard_scoreboard_if #(.AW(5), .FWD_STAGES(3), .FW(2)) hzIf ();

   hazard_scoreboard #(
      .AW(5), .FWD_STAGES(3), .LOAD_LAT(3), .MD_LAT(4), .FW(2)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .hz    (hzIf.slave)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Put every ID-side input into a quiet, hazard-free state.
   task automatic applyStimulus();
      hzIf.i_rs       = '0;
      hzIf.i_rt       = '0;
      hzIf.i_rs_used  = 1'b0;
      hzIf.i_rt_used  = 1'b0;
      hzIf.i_dst      = '0;
      hzIf.i_regwrite = '0;
      hzIf.i_memread  = 1'b0;
      hzIf.i_md_start = 1'b0;
      hzIf.i_md_read  = 1'b0;
      hzIf.i_flush    = 1'b0;
   endtask

   // Pulse reset across a clock edge and release it mid-cycle with quiet inputs.
   task automatic doReset();
      @(negedge i_clk);
      applyStimulus();
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_rst           = 1'b1;
      hzIf.i_rs       = 5'd8;
      hzIf.i_rs_used  = 1'b1;
      hzIf.i_rt       = 5'd8;
      hzIf.i_rt_used  = 1'b1;
      hzIf.i_dst      = {5'd8, 5'd8, 5'd8};
      hzIf.i_regwrite = 3'b111;
      hzIf.i_memread  = 1'b1;
      #1;
      vectors++;
      if (hzIf.o_forward_a !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_fwd_a: got %0d required 0", hzIf.o_forward_a);
      end
      vectors++;
      if ({hzIf.o_bubble, hzIf.o_pcwrite, hzIf.o_idIfwrite, hzIf.o_idIf_flush} !== 4'b1110) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got %b required 1110",
                  {hzIf.o_bubble, hzIf.o_pcwrite, hzIf.o_idIfwrite, hzIf.o_idIf_flush});
      end
      vectors++;
      if (hzIf.o_md_busy !== 1'b0 || hzIf.o_stall_cnt !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_counters: got busy=%b cnt=%0d required busy=0 cnt=0",
                  hzIf.o_md_busy, hzIf.o_stall_cnt);
      end
      @(negedge i_clk);
      applyStimulus();
      i_rst = 1'b0;
   endtask

   task automatic test_forward_priority();
      logic [2:0] regwriteTab [4] = '{3'b111, 3'b110, 3'b100, 3'b000};
      logic [1:0] expectTab   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      doReset();
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         hzIf.i_rs       = 5'd8;
         hzIf.i_rs_used  = 1'b1;
         hzIf.i_dst      = {5'd8, 5'd8, 5'd8};
         hzIf.i_regwrite = regwriteTab[i];
         #1;
         vectors++;
         if (hzIf.o_forward_a !== expectTab[i]) begin
            miscompares++;
            $display("[TB] FAIL fwd_a_prio[%0d]: got %0d required %0d", i, hzIf.o_forward_a, expectTab[i]);
         end
      end
      @(negedge i_clk);
      hzIf.i_rs_used  = 1'b0;
      hzIf.i_regwrite = 3'b111;
      hzIf.i_rt       = 5'd8;
      hzIf.i_rt_used  = 1'b1;
      hzIf.i_dst      = {5'd8, 5'd8, 5'd3};
      #1;
      vectors++;
      if (hzIf.o_forward_a !== 2'd0 || hzIf.o_forward_b !== 2'd2) begin
         miscompares++;
         $display("[TB] FAIL fwd_b_stage1: got a=%0d b=%0d required a=0 b=2",
                  hzIf.o_forward_a, hzIf.o_forward_b);
      end
      applyStimulus();
   endtask

   task automatic test_zero_reg();
      doReset();
      @(negedge i_clk);
      hzIf.i_rs       = 5'd0;
      hzIf.i_rs_used  = 1'b1;
      hzIf.i_dst      = {5'd0, 5'd0, 5'd0};
      hzIf.i_regwrite = 3'b111;
      hzIf.i_memread  = 1'b1;
      #1;
      vectors++;
      if (hzIf.o_forward_a !== 2'd0 || hzIf.o_pcwrite !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL zero_reg: got fwd_a=%0d pcwrite=%b required 0 and 1",
                  hzIf.o_forward_a, hzIf.o_pcwrite);
      end
      @(negedge i_clk);
      hzIf.i_rs_used  = 1'b0;
      hzIf.i_rt       = 5'd9;
      hzIf.i_rt_used  = 1'b0;
      hzIf.i_dst      = {5'd0, 5'd0, 5'd9};
      hzIf.i_regwrite = 3'b001;
      hzIf.i_memread  = 1'b1;
      #1;
      vectors++;
      if (hzIf.o_forward_b !== 2'd0 || hzIf.o_pcwrite !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rt_unused: got fwd_b=%0d pcwrite=%b required 0 and 1",
                  hzIf.o_forward_b, hzIf.o_pcwrite);
      end
      applyStimulus();
   endtask

   task automatic test_load_use();
      logic [2:0] expCtrl [5] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b111};
      logic [2:0] got;
      doReset();
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         hzIf.i_rt       = 5'd5;
         hzIf.i_rt_used  = 1'b1;
         hzIf.i_dst      = {5'd0, 5'd0, 5'd5};
         hzIf.i_regwrite = 3'b001;
         hzIf.i_memread  = (c == 0);
         #1;
         got = {hzIf.o_bubble, hzIf.o_pcwrite, hzIf.o_idIfwrite};
         vectors++;
         if (got !== expCtrl[c]) begin
            miscompares++;
            $display("[TB] FAIL load_use_cycle%0d: got bubble/pc/ifid=%b required %b", c, got, expCtrl[c]);
         end
      end
      vectors++;
      if (hzIf.o_stall_cnt !== 32'd3) begin
         miscompares++;
         $display("[TB] FAIL load_use_stall_cnt: got %0d required 3", hzIf.o_stall_cnt);
      end
      applyStimulus();
   endtask

   task automatic test_mult_div();
      doReset();
      @(negedge i_clk);
      hzIf.i_md_start = 1'b1;
      #1;
      vectors++;
      if (hzIf.o_md_busy !== 1'b0 || hzIf.o_pcwrite !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL md_cycle0: got busy=%b pcwrite=%b required 0 and 1",
                  hzIf.o_md_busy, hzIf.o_pcwrite);
      end
      for (int c = 1; c <= 5; c++) begin
         @(negedge i_clk);
         hzIf.i_md_start = 1'b0;
         hzIf.i_md_read  = 1'b1;
         #1;
         vectors++;
         if (hzIf.o_md_busy !== (c <= 4) || hzIf.o_pcwrite !== (c > 4)) begin
            miscompares++;
            $display("[TB] FAIL md_cycle%0d: got busy=%b pcwrite=%b required busy=%b pcwrite=%b",
                     c, hzIf.o_md_busy, hzIf.o_pcwrite, (c <= 4), (c > 4));
         end
      end
      vectors++;
      if (hzIf.o_stall_cnt !== 32'd4) begin
         miscompares++;
         $display("[TB] FAIL md_stall_cnt: got %0d required 4", hzIf.o_stall_cnt);
      end
      applyStimulus();
   endtask

   task automatic test_flush_ld_wait();
      doReset();
      @(negedge i_clk);
      hzIf.i_rt       = 5'd5;
      hzIf.i_rt_used  = 1'b1;
      hzIf.i_dst      = {5'd0, 5'd0, 5'd5};
      hzIf.i_regwrite = 3'b001;
      hzIf.i_memread  = 1'b1;
      #1;
      vectors++;
      if (hzIf.o_pcwrite !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_detect: got pcwrite=%b required 0", hzIf.o_pcwrite);
      end
      @(negedge i_clk);
      hzIf.i_memread = 1'b0;
      hzIf.i_flush   = 1'b1;
      #1;
      vectors++;
      if ({hzIf.o_idIf_flush, hzIf.o_pcwrite, hzIf.o_bubble, hzIf.o_idIfwrite} !== 4'b1101) begin
         miscompares++;
         $display("[TB] FAIL flush_in_wait: got flush/pc/bubble/ifid=%b required 1101",
                  {hzIf.o_idIf_flush, hzIf.o_pcwrite, hzIf.o_bubble, hzIf.o_idIfwrite});
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge i_clk);
         hzIf.i_flush = 1'b0;
         #1;
         vectors++;
         if ({hzIf.o_idIf_flush, hzIf.o_pcwrite, hzIf.o_bubble} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL flush_after%0d: got flush/pc/bubble=%b required 011",
                     c, {hzIf.o_idIf_flush, hzIf.o_pcwrite, hzIf.o_bubble});
         end
      end
      vectors++;
      if (hzIf.o_stall_cnt !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL flush_stall_cnt: got %0d required 1", hzIf.o_stall_cnt);
      end
      applyStimulus();
   endtask

   task automatic test_async_reset();
      doReset();
      @(negedge i_clk);
      hzIf.i_md_start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge i_clk);
         hzIf.i_md_start = 1'b0;
         hzIf.i_md_read  = 1'b1;
      end
      #1;
      vectors++;
      if (hzIf.o_md_busy !== 1'b1 || hzIf.o_pcwrite !== 1'b0 || hzIf.o_stall_cnt !== 32'd2) begin
         miscompares++;
         $display("[TB] FAIL pre_async: got busy=%b pcwrite=%b cnt=%0d required 1 0 2",
                  hzIf.o_md_busy, hzIf.o_pcwrite, hzIf.o_stall_cnt);
      end
      #1;
      i_rst = 1'b1;
      #1;
      vectors++;
      if (hzIf.o_md_busy !== 1'b0 || hzIf.o_pcwrite !== 1'b1 || hzIf.o_stall_cnt !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got busy=%b pcwrite=%b cnt=%0d required 0 1 0",
                  hzIf.o_md_busy, hzIf.o_pcwrite, hzIf.o_stall_cnt);
      end
      @(negedge i_clk);
      applyStimulus();
      i_rst = 1'b0;
   endtask

   // Run every scenario in order, then report.
   initial begin
      vectors     = 0;
      miscompares = 0;
      i_rst       = 1'b0;
      applyStimulus();
      test_reset();
      test_forward_priority();
      test_zero_reg();
      test_load_use();
      test_mult_div();
      test_flush_ld_wait();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
